// File: rtl/kp_pkg.sv
// Shared types and helpers for the Karplus-Strong voice.
// Holds the voice state encoding, loop-filter modes and saturation.
package kp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RING = 2'd2,
        ST_DAMP = 2'd3
    } kp_state_e;

    localparam logic [1:0] FM_AVG2 = 2'd0;
    localparam logic [1:0] FM_AVG3 = 2'd1;
    localparam logic [1:0] FM_BYP  = 2'd2;
    localparam logic [1:0] FM_HOLD = 2'd3;

    // Clamp a sign-extended value into a signed w-bit range.
    function automatic logic signed [63:0] sat_s(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/kp_loop_filter.sv
// Loop filter: 3-tap tap select feeding a registered gain multiply.
// Output is saturated to the sample width, never wrapped.
module kp_loop_filter
    import kp_pkg::*;
#(
    parameter int DATA_W = 24,
    parameter int GAIN_W = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic        [1:0]        mode,
    input  logic signed [DATA_W-1:0] x0,
    input  logic signed [DATA_W-1:0] x1,
    input  logic signed [DATA_W-1:0] x2,
    input  logic        [GAIN_W-1:0] gain,
    output logic signed [DATA_W-1:0] y
);
    localparam int SW = DATA_W + 2;
    localparam int PW = DATA_W + GAIN_W + 1;

    logic signed [SW-1:0]     sum2;
    logic signed [SW-1:0]     sum3;
    logic signed [DATA_W-1:0] f;
    logic signed [PW-1:0]     prod;
    logic signed [DATA_W-1:0] y_q;
    logic signed [DATA_W-1:0] y_d;

    always_comb begin
        sum2 = SW'(x0) + SW'(x1);
        sum3 = SW'(x0) + (SW'(x1) <<< 1) + SW'(x2);
        f    = x0;
        unique case (mode)
            FM_AVG2, FM_HOLD: f = DATA_W'(sum2 >>> 1);
            FM_AVG3:          f = DATA_W'(sum3 >>> 2);
            FM_BYP:           f = x0;
        endcase
        prod = PW'(f) * PW'($signed({1'b0, gain}));
        y_d  = y_q;
        if (en) y_d = DATA_W'(sat_s(64'(prod >>> GAIN_W), DATA_W));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) y_q <= '0;
        else     y_q <= y_d;
    end

    assign y = y_q;

endmodule

// File: rtl/kp_voice_param.sv
// Parametrised Karplus-Strong plucked-string voice.
// Per sample: decide/read RAM, filter+gain, then write back and output.
module kp_voice_param
    import kp_pkg::*;
#(
    parameter int DATA_W     = 24,
    parameter int ADDR_W     = 10,
    parameter int GAIN_W     = 12,
    parameter int SILENCE_TH = 16
) (
    input  logic                     audio_clk,
    input  logic                     reset,
    input  logic                     sample_en,
    input  logic                     trig,
    input  logic                     note_off,
    input  logic signed [DATA_W-1:0] noise,
    input  logic        [6:0]        velocity,
    input  logic        [GAIN_W-1:0] decay,
    input  logic        [GAIN_W-1:0] damp_decay,
    input  logic        [ADDR_W-1:0] delay_length,
    input  logic        [1:0]        filt_mode,
    output logic signed [DATA_W-1:0] sample_out,
    output logic                     sample_valid,
    output logic                     busy
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int FW    = DATA_W + 9;
    localparam logic signed [DATA_W-1:0] TH_P = DATA_W'(SILENCE_TH);
    localparam logic signed [DATA_W-1:0] TH_N = -TH_P;

    kp_state_e state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] s1_addr_q, s1_addr_d;
    logic [GAIN_W-1:0] s1_gain_q, s1_gain_d;
    logic trig_p_q, trig_p_d, off_p_q, off_p_d;
    logic s1_vld_q, s1_vld_d, s1_fill_q, s1_fill_d;
    logic s2_vld_q, s2_vld_d, vld_q, vld_d;
    logic signed [DATA_W-1:0] fill_q, fill_d;
    logic signed [DATA_W-1:0] x1_q, x1_d, x2_q, x2_d;
    logic signed [DATA_W-1:0] out_q, out_d;

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic signed [DATA_W-1:0] rd_q;
    logic signed [DATA_W-1:0] y;
    logic signed [DATA_W-1:0] wr_data;
    logic signed [FW-1:0]     fill_prod;
    logic [ADDR_W-1:0] len_new, ptr_nxt, cnt_inc;
    logic trig_any, off_any, ptr_last, rd_en, hist_clr;
    logic s1_ring, s2_ring, silent, go_idle;

    assign trig_any  = trig_p_q | trig;
    assign off_any   = off_p_q | note_off;
    assign len_new   = (delay_length < ADDR_W'(2)) ? ADDR_W'(2) : delay_length;
    assign ptr_last  = (ptr_q == len_q - ADDR_W'(1));
    assign ptr_nxt   = ptr_last ? '0 : ptr_q + ADDR_W'(1);
    assign s1_ring   = s1_vld_q & ~s1_fill_q;
    assign s2_ring   = s2_vld_q & ~s1_fill_q;
    assign wr_data   = s1_fill_q ? fill_q : y;
    assign silent    = (wr_data < TH_P) && (wr_data > TH_N);
    assign cnt_inc   = cnt_q + ADDR_W'(1);
    assign fill_prod = FW'(noise) * FW'($signed({1'b0, velocity, velocity[0]}));
    assign go_idle   = s2_ring && silent && (cnt_inc == len_q)
                     && (state_q == ST_RING || state_q == ST_DAMP);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        trig_p_d  = trig_any;
        off_p_d   = off_any;
        s1_vld_d  = 1'b0;
        s1_fill_d = s1_fill_q;
        s1_addr_d = s1_addr_q;
        s1_gain_d = s1_gain_q;
        fill_d    = fill_q;
        rd_en     = 1'b0;
        hist_clr  = 1'b0;
        // Silence is judged on the finished sample, two cycles after its strobe.
        if (s2_ring && (state_q == ST_RING || state_q == ST_DAMP)) begin
            cnt_d = silent ? cnt_inc : '0;
            if (go_idle) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        end
        if (sample_en) begin
            trig_p_d  = 1'b0;
            off_p_d   = 1'b0;
            fill_d    = DATA_W'(sat_s(64'(fill_prod >>> 8), DATA_W));
            s1_addr_d = ptr_q;
            if (trig_any) begin
                state_d   = ST_FILL;
                len_d     = len_new;
                ptr_d     = ADDR_W'(1);
                cnt_d     = '0;
                s1_vld_d  = 1'b1;
                s1_fill_d = 1'b1;
                s1_addr_d = '0;
                hist_clr  = 1'b1;
            end else begin
                unique case (state_q)
                    ST_FILL: begin
                        s1_vld_d  = 1'b1;
                        s1_fill_d = 1'b1;
                        ptr_d     = ptr_nxt;
                        if (ptr_last) state_d = ST_RING;
                    end
                    ST_RING, ST_DAMP: begin
                        s1_vld_d  = 1'b1;
                        s1_fill_d = 1'b0;
                        rd_en     = 1'b1;
                        ptr_d     = ptr_nxt;
                        if (state_q == ST_RING && off_any) state_d = ST_DAMP;
                        s1_gain_d = (state_q == ST_DAMP || off_any) ? damp_decay : decay;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        x1_d     = x1_q;
        x2_d     = x2_q;
        s2_vld_d = s1_vld_q;
        vld_d    = s2_vld_q;
        out_d    = out_q;
        if (s1_ring) begin
            x1_d = rd_q;
            x2_d = x1_q;
        end
        if (hist_clr) begin
            x1_d = '0;
            x2_d = '0;
        end
        if (s2_vld_q) out_d = go_idle ? '0 : wr_data;
    end

    always_ff @(posedge audio_clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            len_q     <= ADDR_W'(2);
            cnt_q     <= '0;
            trig_p_q  <= 1'b0;
            off_p_q   <= 1'b0;
            s1_vld_q  <= 1'b0;
            s1_fill_q <= 1'b0;
            s1_addr_q <= '0;
            s1_gain_q <= '0;
            fill_q    <= '0;
            x1_q      <= '0;
            x2_q      <= '0;
            s2_vld_q  <= 1'b0;
            vld_q     <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            trig_p_q  <= trig_p_d;
            off_p_q   <= off_p_d;
            s1_vld_q  <= s1_vld_d;
            s1_fill_q <= s1_fill_d;
            s1_addr_q <= s1_addr_d;
            s1_gain_q <= s1_gain_d;
            fill_q    <= fill_d;
            x1_q      <= x1_d;
            x2_q      <= x2_d;
            s2_vld_q  <= s2_vld_d;
            vld_q     <= vld_d;
            out_q     <= out_d;
        end
    end

    always_ff @(posedge audio_clk) begin
        if (s2_vld_q) mem[s1_addr_q] <= wr_data;
        if (rd_en)    rd_q <= mem[ptr_q];
    end

    kp_loop_filter #(
        .DATA_W(DATA_W),
        .GAIN_W(GAIN_W)
    ) u_filt (
        .clk (audio_clk),
        .rst (reset),
        .en  (s1_ring),
        .mode(filt_mode),
        .x0  (rd_q),
        .x1  (x1_q),
        .x2  (x2_q),
        .gain(s1_gain_q),
        .y   (y)
    );

    assign sample_out   = out_q;
    assign sample_valid = vld_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_kp_voice_param.sv
// Directed bench for kp_voice_param: fill, ring, damping, retrigger,
// length clamping, saturation and asynchronous reset.
module tb_kp_voice_param;
    localparam int DW = 24;
    localparam int AW = 10;
    localparam int GW = 12;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 sample_en = 1'b0;
    logic                 trig = 1'b0;
    logic                 note_off = 1'b0;
    logic signed [DW-1:0] noise = '0;
    logic        [6:0]    velocity = 7'd127;
    logic        [GW-1:0] decay = 12'hFFF;
    logic        [GW-1:0] damp_decay = 12'hFFF;
    logic        [AW-1:0] delay_length = 10'd4;
    logic        [1:0]    filt_mode = 2'd2;
    logic signed [DW-1:0] sample_out;
    logic                 sample_valid;
    logic                 busy;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    kp_voice_param #(
        .DATA_W(DW), .ADDR_W(AW), .GAIN_W(GW), .SILENCE_TH(16)
    ) dut (
        .audio_clk   (clk),
        .reset       (rst),
        .sample_en   (sample_en),
        .trig        (trig),
        .note_off    (note_off),
        .noise       (noise),
        .velocity    (velocity),
        .decay       (decay),
        .damp_decay  (damp_decay),
        .delay_length(delay_length),
        .filt_mode   (filt_mode),
        .sample_out  (sample_out),
        .sample_valid(sample_valid),
        .busy        (busy)
    );

    // One recirculation with bypass filter and gain 4095/4096.
    function automatic longint ring_of(input longint x);
        return (x * 4095) >>> 12;
    endfunction

    // One sample strobe; vm = valid seen at {+3,+2,+1} cycles.
    task automatic step(input logic t, input logic off,
                        output logic signed [DW-1:0] v, output logic [2:0] vm);
        trig = t; note_off = off; sample_en = 1'b1;
        @(posedge clk); #1;
        trig = 1'b0; note_off = 1'b0; sample_en = 1'b0;
        @(posedge clk); #1; vm[0] = sample_valid;
        @(posedge clk); #1; vm[1] = sample_valid; v = sample_out;
        @(posedge clk); #1; vm[2] = sample_valid;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_run++;
        if (sample_out !== '0) begin
            n_fail++; $display("FAIL reset_out: got %0d want 0", sample_out);
        end
        n_run++;
        if (sample_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", sample_valid);
        end
        n_run++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fill_ring();
        logic signed [DW-1:0] v, e;
        logic [2:0] vm;
        noise = 24'h100000; delay_length = 10'd4; filt_mode = 2'd2; decay = 12'hFFF;
        for (int i = 0; i < 12; i++) begin
            step(i == 0, 1'b0, v, vm);
            e = (i < 4) ? 24'sd1044480 : (i < 8) ? 24'sd1044225 : 24'sd1043970;
            n_run++;
            if (v !== e || vm !== 3'b010) begin
                n_fail++;
                $display("FAIL fill_ring[%0d]: got %0d valid=%b want %0d valid=010", i, v, vm, e);
            end
        end
        n_run++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL fill_ring_busy: got %b want 1", busy);
        end
    endtask

    task automatic test_no_overflow();
        logic signed [DW-1:0] v;
        logic [2:0] vm;
        noise = 24'h7FFFFF; delay_length = 10'd8; filt_mode = 2'd1;
        for (int i = 0; i < 40; i++) begin
            step(i == 0, 1'b0, v, vm);
            if (i == 0) begin
                n_run++;
                if (v !== 24'sh7F7FFF) begin
                    n_fail++; $display("FAIL sat_pos_fill: got %0d want %0d", v, 24'sh7F7FFF);
                end
            end
            if (i == 8) begin
                n_run++;
                if (v !== 24'sd2088449) begin
                    n_fail++; $display("FAIL avg3_first: got %0d want 2088449", v);
                end
            end
            n_run++;
            if (v < 0) begin
                n_fail++; $display("FAIL sat_pos[%0d]: got %0d want >= 0", i, v);
            end
        end
        noise = 24'h800000;
        for (int i = 0; i < 20; i++) begin
            step(i == 0, 1'b0, v, vm);
            if (i == 0) begin
                n_run++;
                if (v !== -24'sd8355840) begin
                    n_fail++; $display("FAIL sat_neg_fill: got %0d want -8355840", v);
                end
            end
            n_run++;
            if (v > 0) begin
                n_fail++; $display("FAIL sat_neg[%0d]: got %0d want <= 0", i, v);
            end
        end
    endtask

    task automatic test_note_off();
        logic signed [DW-1:0] v;
        logic [2:0] vm;
        noise = 24'h100000; delay_length = 10'd4; filt_mode = 2'd2;
        decay = 12'hFFF; damp_decay = 12'h000;
        for (int i = 0; i < 8; i++) step(i == 0, 1'b0, v, vm);
        for (int k = 0; k < 4; k++) begin
            step(1'b0, k == 0, v, vm);
            n_run++;
            if (v !== '0 || vm !== 3'b010 || busy !== (k < 3)) begin
                n_fail++;
                $display("FAIL damp[%0d]: got %0d valid=%b busy=%b want 0 valid=010 busy=%b",
                         k, v, vm, busy, k < 3);
            end
        end
        step(1'b0, 1'b0, v, vm);
        n_run++;
        if (vm !== 3'b000 || busy !== 1'b0 || sample_out !== '0) begin
            n_fail++;
            $display("FAIL idle_after_damp: valid=%b busy=%b out=%0d want 000 0 0", vm, busy, sample_out);
        end
        damp_decay = 12'hFFF;
    endtask

    task automatic test_retrigger();
        logic signed [DW-1:0] v, e;
        logic [2:0] vm;
        noise = 24'h100000; delay_length = 10'd100; filt_mode = 2'd2; decay = 12'hFFF;
        for (int i = 0; i < 105; i++) begin
            step(i == 0, 1'b0, v, vm);
            if (i == 100) begin
                n_run++;
                if (v !== 24'sd1044225) begin
                    n_fail++; $display("FAIL long_first_ring: got %0d want 1044225", v);
                end
            end
        end
        delay_length = 10'd50; noise = 24'h080000;
        for (int i = 0; i < 150; i++) begin
            step(i == 0, 1'b0, v, vm);
            e = (i < 50) ? 24'sd522240 : (i < 100) ? 24'sd522112 : 24'sd521984;
            n_run++;
            if (v !== e || vm !== 3'b010 || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL retrig[%0d]: got %0d valid=%b busy=%b want %0d", i, v, vm, busy, e);
            end
        end
    endtask

    task automatic test_clamp();
        logic signed [DW-1:0] v;
        logic [2:0] vm;
        longint m [2];
        longint e;
        filt_mode = 2'd2; decay = 12'hFFF; delay_length = 10'd0;
        m[0] = 1044480; m[1] = 2088960;
        for (int i = 0; i < 10; i++) begin
            noise = (i == 0) ? 24'h100000 : 24'h200000;
            step(i == 0, 1'b0, v, vm);
            if (i >= 2) m[i % 2] = ring_of(m[i % 2]);
            e = m[i % 2];
            n_run++;
            if (longint'(v) != e || vm !== 3'b010) begin
                n_fail++; $display("FAIL clamp_lo[%0d]: got %0d valid=%b want %0d", i, v, vm, e);
            end
        end
        delay_length = 10'h3FF;
        for (int i = 0; i < 1025; i++) begin
            noise = (i == 0) ? 24'h100000 : 24'h200000;
            step(i == 0, 1'b0, v, vm);
            e = (i == 0) ? 1044480 : (i == 1022) ? 2088960 :
                (i == 1023) ? 1044225 : 2088450;
            if (i == 0 || i >= 1022) begin
                n_run++;
                if (longint'(v) != e || vm !== 3'b010) begin
                    n_fail++; $display("FAIL clamp_hi[%0d]: got %0d valid=%b want %0d", i, v, vm, e);
                end
            end
        end
    endtask

    task automatic test_reset_mid_ring();
        logic signed [DW-1:0] v;
        logic [2:0] vm;
        noise = 24'h100000; delay_length = 10'd4; filt_mode = 2'd2;
        for (int i = 0; i < 6; i++) step(i == 0, 1'b0, v, vm);
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        n_run++;
        if (sample_out !== '0 || busy !== 1'b0 || sample_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: out=%0d busy=%b valid=%b want 0 0 0", sample_out, busy, sample_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        step(1'b0, 1'b0, v, vm);
        n_run++;
        if (vm !== 3'b000 || v !== '0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: out=%0d valid=%b busy=%b want 0 000 0", v, vm, busy);
        end
        step(1'b1, 1'b0, v, vm);
        n_run++;
        if (vm !== 3'b010 || v !== 24'sd1044480) begin
            n_fail++; $display("FAIL post_reset_trig: out=%0d valid=%b want 1044480 010", v, vm);
        end
    endtask

    initial begin
        test_reset();
        test_fill_ring();
        test_no_overflow();
        test_note_off();
        test_retrigger();
        test_clamp();
        test_reset_mid_ring();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
